// File: rtl/diff_ser_tx_pkg.sv
// Shared definitions for the differential serial transmitter: FSM encoding,
// legal parameter ranges and a counter-width helper.
package diff_ser_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAPW  = 2'd2
    } tx_state_e;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;
    localparam int DIV_MIN   = 1;
    localparam int DIV_MAX   = 256;
    localparam int GAP_MIN   = 0;
    localparam int GAP_MAX   = 15;
    localparam int GAP_CNT_W = 4;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/diff_ser_tx_if.sv
// Word handshake and differential output bundle of diff_ser_tx.
interface diff_ser_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] DATA;
    logic             VALID;
    logic             READY;
    logic             BUSY;
    logic             DONE;
    logic             O;
    logic             OB;

    modport slave (
        input  DATA, VALID,
        output READY, BUSY, DONE, O, OB
    );

    modport master (
        output DATA, VALID,
        input  READY, BUSY, DONE, O, OB
    );
endinterface

// File: rtl/diff_tx_bit_tick.sv
// Bit-period divider: pulses o_tick on the last cycle of every DIV-cycle
// period while enabled; restarts from zero whenever disabled.
module diff_tx_bit_tick
    import diff_ser_tx_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic i_en,
    output logic o_tick
);

    localparam int               CNT_W    = cnt_width(DIV);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_tick = i_en && (r_cnt == LAST_CNT);

    always_ff @(posedge CLK) begin
        if (!RST_N || !i_en) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST_CNT) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/diff_ser_tx.sv
// MSB-first parallel-to-serial transmitter with a differential output pair,
// per-bit clock divider and a configurable idle gap between words.
module diff_ser_tx
    import diff_ser_tx_pkg::*;
#(
    parameter int   WIDTH    = 8,
    parameter int   DIV      = 1,
    parameter int   GAP      = 1,
    parameter logic IDLE_VAL = 1'b0
) (
    input  logic          CLK,
    input  logic          RST_N,
    diff_ser_tx_if.slave  bus
);

    localparam int               BIT_W    = cnt_width(WIDTH);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("diff_ser_tx: WIDTH out of range");
    end
    if (DIV < DIV_MIN || DIV > DIV_MAX) begin : g_bad_div
        $error("diff_ser_tx: DIV out of range");
    end
    if (GAP < GAP_MIN || GAP > GAP_MAX) begin : g_bad_gap
        $error("diff_ser_tx: GAP out of range");
    end

    tx_state_e            r_state;
    logic [WIDTH-1:0]     r_shift;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [GAP_CNT_W-1:0] r_gap_cnt;
    logic                 r_o;
    logic                 r_done;
    logic                 w_ready;
    logic                 w_tick;

    assign w_ready   = (r_state == ST_IDLE) && RST_N;
    assign bus.READY = w_ready;
    assign bus.BUSY  = (r_state != ST_IDLE);
    assign bus.DONE  = r_done;
    // Both legs come from the one r_o flop so they can never agree.
    assign bus.O     = r_o;
    assign bus.OB    = ~r_o;

    diff_tx_bit_tick #(
        .DIV (DIV)
    ) u_bit_tick (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .i_en   (r_state == ST_SHIFT),
        .o_tick (w_tick)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_o       <= IDLE_VAL;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.VALID) begin
                        // MSB goes straight to the output; r_shift holds the rest.
                        r_state   <= ST_SHIFT;
                        r_o       <= bus.DATA[WIDTH-1];
                        r_shift   <= {bus.DATA[WIDTH-2:0], 1'b0};
                        r_bit_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (w_tick) begin
                        if (r_bit_cnt == LAST_BIT) begin
                            r_o       <= IDLE_VAL;
                            r_done    <= 1'b1;
                            r_bit_cnt <= '0;
                            if (GAP == 0) begin
                                r_state <= ST_IDLE;
                            end else begin
                                r_state   <= ST_GAPW;
                                r_gap_cnt <= GAP_CNT_W'(GAP - 1);
                            end
                        end else begin
                            r_o       <= r_shift[WIDTH-1];
                            r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                ST_GAPW: begin
                    if (r_gap_cnt == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_o     <= IDLE_VAL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_diff_ser_tx.sv
// Directed-vector bench for diff_ser_tx: three parameterisations sharing one
// clock and reset, with hand-computed serial waveforms.
module tb_diff_ser_tx;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit mon_en      = 1'b0;

    int a5_o [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    int done_cnt;
    int second_xfer;

    diff_ser_tx_if #(.WIDTH(8)) bus0 ();
    diff_ser_tx_if #(.WIDTH(8)) bus1 ();
    diff_ser_tx_if #(.WIDTH(8)) bus2 ();

    diff_ser_tx #(.WIDTH(8), .DIV(1), .GAP(1), .IDLE_VAL(1'b0)) u_dut0 (
        .CLK (clk), .RST_N (rst_n), .bus (bus0)
    );
    diff_ser_tx #(.WIDTH(8), .DIV(4), .GAP(1), .IDLE_VAL(1'b0)) u_dut1 (
        .CLK (clk), .RST_N (rst_n), .bus (bus1)
    );
    diff_ser_tx #(.WIDTH(8), .DIV(1), .GAP(0), .IDLE_VAL(1'b0)) u_dut2 (
        .CLK (clk), .RST_N (rst_n), .bus (bus2)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Every cycle: legs must differ and READY must never overlap BUSY.
    always @(negedge clk) begin
        if (mon_en) begin
            check_vec("o_ne_ob_0", {31'b0, bus0.O != bus0.OB}, 32'd1);
            check_vec("o_ne_ob_1", {31'b0, bus1.O != bus1.OB}, 32'd1);
            check_vec("o_ne_ob_2", {31'b0, bus2.O != bus2.OB}, 32'd1);
            check_vec("rdy_busy_0", {31'b0, bus0.READY && bus0.BUSY}, 32'd0);
            check_vec("rdy_busy_1", {31'b0, bus1.READY && bus1.BUSY}, 32'd0);
            check_vec("rdy_busy_2", {31'b0, bus2.READY && bus2.BUSY}, 32'd0);
        end
    end

    initial begin
        rst_n      = 1'b0;
        bus0.VALID = 1'b0; bus0.DATA = 8'h00;
        bus1.VALID = 1'b0; bus1.DATA = 8'h00;
        bus2.VALID = 1'b0; bus2.DATA = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        check_vec("rst_ready", bus0.READY, 0);
        check_vec("rst_o",     bus0.O,     0);
        check_vec("rst_ob",    bus0.OB,    1);
        check_vec("rst_busy",  bus0.BUSY,  0);
        check_vec("rst_done",  bus0.DONE,  0);
        rst_n = 1'b1;
        @(negedge clk);
        check_vec("rel_ready", bus0.READY, 1);
        check_vec("rel_o",     bus0.O,     0);

        // 8'hA5, DIV=1, GAP=1
        bus0.DATA  = 8'hA5;
        bus0.VALID = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k <= 8) begin
                check_vec($sformatf("a5_o_c%0d", k),    bus0.O,    a5_o[k-1]);
                check_vec($sformatf("a5_done_c%0d", k), bus0.DONE, 0);
                check_vec($sformatf("a5_busy_c%0d", k), bus0.BUSY, 1);
            end else if (k == 9) begin
                check_vec("a5_o_c9",     bus0.O,     0);
                check_vec("a5_done_c9",  bus0.DONE,  1);
                check_vec("a5_ready_c9", bus0.READY, 0);
            end else begin
                check_vec("a5_ready_c10", bus0.READY, 1);
                check_vec("a5_done_c10",  bus0.DONE,  0);
                check_vec("a5_busy_c10",  bus0.BUSY,  0);
            end
            if (k == 1) begin
                bus0.VALID = 1'b0;
                bus0.DATA  = 8'h00;
            end
        end

        // 8'h80, DIV=4
        done_cnt   = 0;
        bus1.DATA  = 8'h80;
        bus1.VALID = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            if (k <= 32)
                check_vec($sformatf("div4_o_c%0d", k), bus1.O, (k <= 4) ? 1 : 0);
            if (bus1.DONE) begin
                done_cnt++;
                check_vec("div4_done_cycle", k, 33);
            end
            if (k == 34) check_vec("div4_ready_c34", bus1.READY, 1);
            if (k == 1) begin
                bus1.VALID = 1'b0;
                bus1.DATA  = 8'hFF;
            end
        end
        check_vec("div4_done_count", done_cnt, 1);

        // Back-to-back 8'hFF, 8'h00 with VALID held, GAP=0
        second_xfer = -1;
        check_vec("gap0_ready_c0", bus2.READY, 1);
        bus2.DATA  = 8'hFF;
        bus2.VALID = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            if (k <= 18) begin
                check_vec($sformatf("gap0_o_c%0d", k),    bus2.O,    (k <= 8) ? 1 : 0);
                check_vec($sformatf("gap0_done_c%0d", k), bus2.DONE, (k == 9 || k == 18) ? 1 : 0);
            end
            if (bus2.VALID && bus2.READY && second_xfer < 0) second_xfer = k;
            if (k == 1)  bus2.DATA  = 8'h00;
            if (k == 10) bus2.VALID = 1'b0;
            if (k == 19) check_vec("gap0_ready_c19", bus2.READY, 1);
        end
        check_vec("gap0_spacing", second_xfer, 9);

        // Reset in the middle of 8'hC3
        bus0.DATA  = 8'hC3;
        bus0.VALID = 1'b1;
        @(negedge clk);
        bus0.VALID = 1'b0;
        check_vec("c3_o_c1", bus0.O, 1);
        @(negedge clk);
        check_vec("c3_o_c2", bus0.O, 1);
        @(negedge clk);
        check_vec("c3_o_c3", bus0.O, 0);
        check_vec("c3_busy_c3", bus0.BUSY, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_vec("abort_o",     bus0.O,     0);
        check_vec("abort_ob",    bus0.OB,    1);
        check_vec("abort_busy",  bus0.BUSY,  0);
        check_vec("abort_done",  bus0.DONE,  0);
        check_vec("abort_ready", bus0.READY, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_vec("abort_rel_ready", bus0.READY, 1);
        check_vec("abort_rel_busy",  bus0.BUSY,  0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check_vec($sformatf("abort_tail_done_%0d", k), bus0.DONE, 0);
            check_vec($sformatf("abort_tail_o_%0d", k),    bus0.O,    0);
        end

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
